mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the MIPS datapath, sitting beside the combinational ALU in the execute stage. It accepts signed/unsigned multiply and divide requests, runs them with a fixed multi-cycle latency, and holds results in the architectural HI/LO registers. It also services direct HI/LO writes. Its busy indication drives the pipeline stall logic.

## Interface
- No parameters. Latencies are fixed: MULT_CYC = 5 and DIV_CYC = 10.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled with opMDU on the rising edge
- opMDU  in  4  operation code:
  - 4'b0000 NONE
  - 4'b0001 MULT
  - 4'b0010 MULTU
  - 4'b0011 DIV
  - 4'b0100 DIVU
  - 4'b0101 MTHI
  - 4'b0110 MTLO
  - all other codes: NONE
- SrcA  in  32  operand A: rs, dividend, or MTHI/MTLO source
- SrcB  in  32  operand B: rt, divisor
- busy  out  1  registered; high while an operation is in flight
- stall_req  out  1  combinational: busy | (start & opMDU is MULT/MULTU/DIV/DIVU)
- HI  out  32  HI register, direct register output (used for MFHI)
- LO  out  32  LO register, direct register output (used for MFLO)

## Operation
- Reset (rst_n low, at any time, including mid-operation):
  - HI = 0, LO = 0, busy = 0, counter = 0.
  - Any pending result is discarded.
- Idle, start = 1, op MULT/MULTU/DIV/DIVU: accept the request.
  - Latch the computed 64-bit result into internal pending registers.
  - Load the counter with MULT_CYC or DIV_CYC.
  - Set busy = 1.
- Busy: the counter decrements on each edge. On the edge where the counter is 1:
  - HI/LO are loaded from the pending registers.
  - busy clears to 0.
  - counter returns to 0.
- MULT: {HI,LO} = $signed(SrcA) * $signed(SrcB), full 64-bit result.
- MULTU: same as MULT, with both operands zero-extended.
- DIV: LO = quotient, HI = remainder, signed.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- DIVU: LO = quotient, HI = remainder, unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is defined behaviour, not an error.
- DIV or DIVU with divisor 0:
  - The operation still occupies DIV_CYC cycles with busy high.
  - HI/LO are left unchanged on completion.
- MTHI/MTLO, idle: HI (or LO) = SrcA on the sampling edge; busy is not asserted.
- Any start while busy = 1 is ignored, including MTHI/MTLO. The pipeline holds the instruction via stall_req.
- start = 0, or opMDU NONE/undefined: no state change.

## Timing
- Edge E0 accepts a MULT. busy is high after E0 through E4. HI/LO are updated at E5, and busy is low after E5.
  - Visible results: 5 cycles after acceptance.
- DIV/DIVU: the same pattern with 10 cycles. HI/LO are updated at E10.
- A new request can be accepted at the same edge that completes the previous one only if busy is already low. The earliest back-to-back acceptance is the edge after completion (E6 for MULT).
- MTHI/MTLO complete in 0 added cycles. The value is visible on HI/LO immediately after the sampling edge.
- stall_req goes high combinationally in the accept cycle, so the issuing instruction stalls with no bubble loss. It falls in the cycle after completion.
- HI/LO never change while busy = 1, except through asynchronous reset.
- Async reset asserts immediately, independent of clk. Deassertion is assumed synchronised upstream.

## Test plan
- MULT SrcA = 0xFFFFFFFF, SrcB = 0x00000002 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE after exactly 5 edges. busy is high for exactly 5 cycles.
- MULTU with the same operands -> HI = 0x00000001, LO = 0xFFFFFFFE. DIVU 7 / 2 -> LO = 3, HI = 1 after 10 edges.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- MTHI 0x12345678, then DIV x / 0 -> busy for 10 cycles, HI stays 0x12345678.
- MULT in flight, MTLO 0xAAAA5555 issued on cycle 2 -> MTLO ignored, stall_req stays high. The MULT result lands at E5.
- DIV in flight, rst_n pulsed low at cycle 4 -> HI = LO = 0 and busy = 0 immediately. No late write-back after reset.

Source files
------------

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit for the MIPS execute stage.
//
// Accepts signed/unsigned multiply and divide requests, computes the 64-bit
// result on the accept edge into pending registers, and commits them to the
// architectural HI/LO registers after a fixed latency (5 cycles for
// multiply, 10 for divide). MTHI/MTLO write HI/LO directly when idle.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request strobe, sampled with opMDU
//   opMDU      operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO, else NONE)
//   SrcA       operand A: rs / dividend / MTHI-MTLO source
//   SrcB       operand B: rt / divisor
//   busy       high while a multiply/divide is in flight
//   stall_req  busy, or a multiply/divide being presented this cycle
//   HI, LO     architectural HI/LO registers
// ---------------------------------------------------------------------------
module mdu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  opMDU,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0101;
   localparam logic [3:0] OP_MTLO  = 4'b0110;

   localparam logic [3:0] MULT_CYC = 4'd5;
   localparam logic [3:0] DIV_CYC  = 4'd10;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_pendHi;
   logic [31:0] r_pendLo;
   logic        r_pendWr;

   logic        w_isMult;
   logic        w_isMultu;
   logic        w_isDiv;
   logic        w_isDivu;
   logic        w_isMul;
   logic        w_isMulDiv;
   logic        w_accept;
   logic        w_done;
   logic        w_idle;

   logic [63:0] w_opA64;
   logic [63:0] w_opB64;
   logic [63:0] w_prod;

   logic        w_negA;
   logic        w_negB;
   logic [31:0] w_magA;
   logic [31:0] w_magB;
   logic        w_divZero;
   logic [31:0] w_divisor;
   logic [31:0] w_quoMag;
   logic [31:0] w_remMag;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   logic [31:0] w_resHi;
   logic [31:0] w_resLo;
   logic        w_resWr;

   assign w_isMult   = (opMDU == OP_MULT);
   assign w_isMultu  = (opMDU == OP_MULTU);
   assign w_isDiv    = (opMDU == OP_DIV);
   assign w_isDivu   = (opMDU == OP_DIVU);
   assign w_isMul    = w_isMult | w_isMultu;
   assign w_isMulDiv = w_isMul | w_isDiv | w_isDivu;
   assign w_idle     = (r_state == S_IDLE);

   // One shared 64x64 multiplier; keeping the low 64 bits of the extended
   // operands gives the exact signed or unsigned 32x32 product.
   assign w_opA64 = w_isMult ? {{32{SrcA[31]}}, SrcA} : {32'd0, SrcA};
   assign w_opB64 = w_isMult ? {{32{SrcB[31]}}, SrcB} : {32'd0, SrcB};
   assign w_prod  = w_opA64 * w_opB64;

   // Signed divide is done on magnitudes with one unsigned divider, then the
   // signs are restored: quotient negative when signs differ, remainder takes
   // the dividend's sign. The magnitude of 0x80000000 is 0x80000000 as an
   // unsigned value, so 0x80000000 / -1 naturally yields 0x80000000, rem 0.
   // A zero divisor is replaced by 1 only to keep the divider defined; the
   // result is never committed in that case.
   assign w_negA    = w_isDiv & SrcA[31];
   assign w_negB    = w_isDiv & SrcB[31];
   assign w_magA    = w_negA ? (~SrcA + 32'd1) : SrcA;
   assign w_magB    = w_negB ? (~SrcB + 32'd1) : SrcB;
   assign w_divZero = (SrcB == 32'd0);
   assign w_divisor = w_divZero ? 32'd1 : w_magB;
   assign w_quoMag  = w_magA / w_divisor;
   assign w_remMag  = w_magA % w_divisor;
   assign w_quo     = (w_negA ^ w_negB) ? (~w_quoMag + 32'd1) : w_quoMag;
   assign w_rem     = w_negA ? (~w_remMag + 32'd1) : w_remMag;

   assign w_resHi = w_isMul ? w_prod[63:32] : w_rem;
   assign w_resLo = w_isMul ? w_prod[31:0]  : w_quo;
   assign w_resWr = w_isMul | ~w_divZero;

   // Next-state logic: a multiply/divide is only accepted when idle, and the
   // operation completes on the edge where the counter reads 1.
   always_comb begin
      w_stateNext = r_state;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && w_isMulDiv) begin
               w_accept    = 1'b1;
               w_stateNext = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd1) begin
               w_done      = 1'b1;
               w_stateNext = S_IDLE;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Latency counter and pending result, captured on the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= 4'd0;
         r_pendHi <= 32'd0;
         r_pendLo <= 32'd0;
         r_pendWr <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= w_isMul ? MULT_CYC : DIV_CYC;
         r_pendHi <= w_resHi;
         r_pendLo <= w_resLo;
         r_pendWr <= w_resWr;
      end else if (r_state == S_BUSY) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // HI/LO: committed from the pending result on completion, or written
   // directly by MTHI/MTLO when idle. Nothing touches them while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_done) begin
         if (r_pendWr) begin
            r_hi <= r_pendHi;
            r_lo <= r_pendLo;
         end
      end else if (w_idle && start) begin
         if (opMDU == OP_MTHI) begin
            r_hi <= SrcA;
         end
         if (opMDU == OP_MTLO) begin
            r_lo <= SrcA;
         end
      end
   end

   assign busy      = (r_state == S_BUSY);
   assign stall_req = busy | (start & w_isMulDiv);
   assign HI        = r_hi;
   assign LO        = r_lo;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu.
//
// Directed vectors with hand-computed results. Each multiply/divide pushes
// its expected HI/LO and busy length into a scoreboard queue; a monitor on
// the falling clock edge pops and compares whenever busy drops, and also
// confirms HI/LO stay frozen while busy. MTHI/MTLO, undefined opcodes and
// reset behaviour are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_mdu;

   localparam logic [3:0] OP_NONE  = 4'b0000;
   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0101;
   localparam logic [3:0] OP_MTLO  = 4'b0110;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } expEntry_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  opMDU;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        stall_req;
   logic [31:0] HI;
   logic [31:0] LO;

   expEntry_t   sbQ[$];
   int          checksTotal  = 0;
   int          checksPassed = 0;

   logic        prevBusy = 1'b0;
   int          busyCnt  = 0;
   logic [31:0] snapHi   = 32'd0;
   logic [31:0] snapLo   = 32'd0;

   mdu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .opMDU     (opMDU),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .busy      (busy),
      .stall_req (stall_req),
      .HI        (HI),
      .LO        (LO)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checksTotal++;
      if (actual === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive one request for a single sampling edge, checking stall_req while
   // it is presented; returns on the following falling edge.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic expStall);
      start = 1'b1;
      opMDU = op;
      SrcA  = a;
      SrcB  = b;
      #1;
      checkOutput("stallReqIssue", {31'd0, stall_req}, {31'd0, expStall});
      @(posedge clk);
      #1;
      start = 1'b0;
      opMDU = OP_NONE;
      @(negedge clk);
   endtask

   // Wait (bounded) on falling edges until busy drops; stall_req must then
   // be low too since nothing is being presented.
   task automatic waitIdle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idleTimeout", {31'd0, busy}, 32'd0);
      checkOutput("stallReqIdle", {31'd0, stall_req}, 32'd0);
   endtask

   task automatic pushExp(input logic [31:0] hi, input logic [31:0] lo, input int cycles);
      expEntry_t e;
      e.hi     = hi;
      e.lo     = lo;
      e.cycles = cycles;
      sbQ.push_back(e);
   endtask

   // Monitor: counts busy cycles, checks HI/LO are frozen while busy, and
   // compares against the scoreboard head on each busy falling transition.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevBusy = 1'b0;
         busyCnt  = 0;
      end else begin
         if (busy) begin
            if (!prevBusy) begin
               snapHi = HI;
               snapLo = LO;
            end else begin
               checkOutput("hiHeldWhileBusy", HI, snapHi);
               checkOutput("loHeldWhileBusy", LO, snapLo);
            end
            busyCnt++;
         end else if (prevBusy) begin
            checkOutput("sbHasEntry", {31'd0, sbQ.size() != 0}, 32'd1);
            if (sbQ.size() != 0) begin
               expEntry_t e;
               e = sbQ.pop_front();
               checkOutput("resultHI", HI, e.hi);
               checkOutput("resultLO", LO, e.lo);
               checkOutput("busyCycles", busyCnt, e.cycles);
            end
            busyCnt = 0;
         end
         prevBusy = busy;
      end
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      opMDU = OP_NONE;
      SrcA  = 32'd0;
      SrcB  = 32'd0;

      // Reset state.
      repeat (2) @(posedge clk);
      #2;
      checkOutput("resetHI", HI, 32'd0);
      checkOutput("resetLO", LO, 32'd0);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // -1 * 2 signed = -2.
      pushExp(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
      applyStimulus(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 1'b1);
      waitIdle();

      // Same operands unsigned: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE. Issued the
      // cycle after completion to exercise back-to-back acceptance.
      pushExp(32'h00000001, 32'hFFFFFFFE, 5);
      applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b1);
      waitIdle();

      // 7 / 2 unsigned: q 3, r 1.
      pushExp(32'h00000001, 32'h00000003, 10);
      applyStimulus(OP_DIVU, 32'd7, 32'd2, 1'b1);
      waitIdle();

      // -7 / 2 signed: q -3, r -1.
      pushExp(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
      waitIdle();

      // Most-negative / -1: q 0x80000000, r 0.
      pushExp(32'h00000000, 32'h80000000, 10);
      applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      waitIdle();

      // MTHI when idle: immediate, no busy.
      applyStimulus(OP_MTHI, 32'h12345678, 32'd0, 1'b0);
      checkOutput("mthiHI", HI, 32'h12345678);
      checkOutput("mthiLO", LO, 32'h80000000);
      checkOutput("mthiBusy", {31'd0, busy}, 32'd0);

      // Divide by zero: still 10 busy cycles, HI/LO untouched.
      pushExp(32'h12345678, 32'h80000000, 10);
      applyStimulus(OP_DIV, 32'd5, 32'd0, 1'b1);
      waitIdle();

      // Undefined opcode: no effect.
      applyStimulus(4'b0111, 32'hDEADBEEF, 32'd1, 1'b0);
      checkOutput("undefHI", HI, 32'h12345678);
      checkOutput("undefLO", LO, 32'h80000000);
      checkOutput("undefBusy", {31'd0, busy}, 32'd0);

      // MULT 7 * 6 with an MTLO presented at E2: MTLO ignored, stall held.
      pushExp(32'h00000000, 32'h0000002A, 5);
      applyStimulus(OP_MULT, 32'd7, 32'd6, 1'b1);
      @(negedge clk);
      applyStimulus(OP_MTLO, 32'hAAAA5555, 32'd0, 1'b1);
      checkOutput("stallReqBusy", {31'd0, stall_req}, 32'd1);
      waitIdle();

      // Reset in the middle of a divide: immediate clear, no late write-back.
      applyStimulus(OP_MTHI, 32'hCAFEF00D, 32'd0, 1'b0);
      checkOutput("mthi2HI", HI, 32'hCAFEF00D);
      applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midResetHI", HI, 32'd0);
      checkOutput("midResetLO", LO, 32'd0);
      checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      checkOutput("noLateWbHI", HI, 32'd0);
      checkOutput("noLateWbLO", LO, 32'd0);
      checkOutput("noLateWbBusy", {31'd0, busy}, 32'd0);

      // Unit still works after reset: 0x10000 * 0x10000 = 1_00000000.
      pushExp(32'h00000001, 32'h00000000, 5);
      applyStimulus(OP_MULTU, 32'h00010000, 32'h00010000, 1'b1);
      waitIdle();

      repeat (2) @(negedge clk);
      checkOutput("sbDrained", sbQ.size(), 32'd0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
